gb_cpu_interrupt_ctrl: RTL

Interrupt controller for the Game Boy CPU. It holds IE (0xFFFF) and IF (0xFF0F) and edge-detects the five peripheral request lines. It manages IME, including the one-instruction EI delay, and sequences the 5 M-cycle interrupt dispatch. It drives the regfile's write_interrupt_vector / interrupt_vector inputs and the PC push strobes consumed by the CPU control unit. One clk edge corresponds to one M-cycle.

---
 rtl/gb_cpu_interrupt_ctrl_if.sv | 41 ++++
 rtl/gb_cpu_interrupt_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_cpu_interrupt_ctrl_if.sv
// ----------------------------------------------------------------------------
// gb_cpu_interrupt_ctrl_if
//   CPU data-bus view seen by the interrupt controller.
//
//   Signals:
//     bus_addr   16  address presented by the CPU
//     bus_wdata   8  write data
//     bus_wren    1  write strobe
//     bus_rdata   8  read data returned by the controller
//
//   Handshake: there is no valid/ready pair on this bus. A write is a
//   single-cycle strobe: when bus_wren is high at a clk posedge the write
//   to bus_addr is taken at that edge, unconditionally, with no
//   backpressure. Reads are combinational: bus_rdata follows bus_addr in
//   the same cycle and reflects register contents before any write
//   landing at the coming edge.
//
//   Modports:
//     master  CPU side (drives address/data/strobe, receives read data)
//     slave   controller side
// ----------------------------------------------------------------------------
interface gb_cpu_interrupt_ctrl_if;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_wren;
  logic [7:0]  bus_rdata;

  modport master (
    output bus_addr,
    output bus_wdata,
    output bus_wren,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr,
    input  bus_wdata,
    input  bus_wren,
    output bus_rdata
  );
endinterface

// File: rtl/gb_cpu_interrupt_ctrl.sv
// ----------------------------------------------------------------------------
// gb_cpu_interrupt_ctrl
//   Game Boy CPU interrupt controller. Holds IE (0xFFFF) and IF (0xFF0F),
//   edge-detects the peripheral request lines, manages IME including the
//   one-instruction EI delay, and sequences the 5 M-cycle dispatch
//   (D1..D5). One clk posedge is one M-cycle.
//
//   Ports:
//     clk                     machine clock
//     reset                   synchronous, active-high
//     irq_in[NUM_IRQ]         peripheral request levels (rising edge sets IF)
//     bus                     CPU data bus (slave modport)
//     cmd_ei/cmd_di/cmd_reti  1-cycle pulses from the instruction decoder
//     instr_boundary          last M-cycle of the current instruction
//     ime                     interrupt master enable
//     halt_wake               |(IE & IF), independent of IME
//     dispatch_active         high in D1..D5
//     push_pc_hi              high in D3 (PC_H pushed)
//     push_pc_lo              high in D4 (PC_L pushed)
//     write_interrupt_vector  high in D5 only
//     interrupt_vector        vector valid in D5, 8'h00 otherwise
//     dbg_state               current dispatch FSM state
// ----------------------------------------------------------------------------
module gb_cpu_interrupt_ctrl #(
  parameter int         NUM_IRQ     = 5,
  parameter logic [7:0] VECTOR_BASE = 8'h40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  gb_cpu_interrupt_ctrl_if.slave bus,
  input  logic               cmd_ei,
  input  logic               cmd_di,
  input  logic               cmd_reti,
  input  logic               instr_boundary,
  output logic               ime,
  output logic               halt_wake,
  output logic               dispatch_active,
  output logic               push_pc_hi,
  output logic               push_pc_lo,
  output logic               write_interrupt_vector,
  output logic [7:0]         interrupt_vector,
  output logic [2:0]         dbg_state
);

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_D1   = 3'd1,
    ST_D2   = 3'd2,
    ST_D3   = 3'd3,
    ST_D4   = 3'd4,
    ST_D5   = 3'd5
  } state_t;

  state_t             state;
  logic [7:0]         ie_q;
  logic [NUM_IRQ-1:0] if_q;
  logic [NUM_IRQ-1:0] irq_prev;
  logic               ei_delay;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [7:0]         vector_q;

  // --------------------------------------------------------------------------
  // Bus decode and combinational read-back
  // --------------------------------------------------------------------------
  logic wr_if;
  logic wr_ie;

  assign wr_if = bus.bus_wren && (bus.bus_addr == ADDR_IF);
  assign wr_ie = bus.bus_wren && (bus.bus_addr == ADDR_IE);

  always_comb begin
    bus.bus_rdata = 8'h00;
    if (bus.bus_addr == ADDR_IF)
      bus.bus_rdata = {{(8-NUM_IRQ){1'b1}}, if_q};
    else if (bus.bus_addr == ADDR_IE)
      bus.bus_rdata = ie_q;
  end

  // --------------------------------------------------------------------------
  // Request edge detection and IF next value
  // --------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] irq_edge;
  logic [NUM_IRQ-1:0] if_written;
  logic [NUM_IRQ-1:0] if_next;

  assign irq_edge   = irq_in & ~irq_prev;
  assign if_written = wr_if ? bus.bus_wdata[NUM_IRQ-1:0] : if_q;
  // The OR with irq_edge comes last so a fresh request survives both a
  // same-cycle bus write and the dispatch clear at the end of D5.
  assign if_next    = (if_written & ~((state == ST_D5) ? clr_mask : {NUM_IRQ{1'b0}}))
                    | irq_edge;

  // --------------------------------------------------------------------------
  // Pending / wake / effective IME
  // --------------------------------------------------------------------------
  logic pending;
  logic ime_eff;
  logic enter_d1;

  assign pending   = |(ie_q[NUM_IRQ-1:0] & if_q);
  assign halt_wake = pending;
  // EI's delay has elapsed once a boundary is reached without another EI
  // in flight; ime_eff lets that boundary dispatch without waiting for the
  // IME register to catch up.
  assign ime_eff   = ime | (ei_delay & ~cmd_ei);
  assign enter_d1  = (state == ST_IDLE) && instr_boundary && ime_eff && pending && !cmd_di;

  // --------------------------------------------------------------------------
  // D4 priority resolution. Uses IE/IF as they stand in D4 including a bus
  // write made in that same cycle, so a push onto 0xFFFF can cancel.
  // --------------------------------------------------------------------------
  logic [7:0]         res_ie;
  logic [NUM_IRQ-1:0] res_req;
  logic               res_found;
  logic [7:0]         res_idx;
  logic [NUM_IRQ-1:0] res_mask;
  logic [7:0]         res_vector;

  assign res_ie  = wr_ie ? bus.bus_wdata : ie_q;
  assign res_req = res_ie[NUM_IRQ-1:0] & if_written;

  always_comb begin
    res_found = 1'b0;
    res_idx   = 8'h00;
    res_mask  = {NUM_IRQ{1'b0}};
    // Scan downward so the lowest set index is the one left standing.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (res_req[i]) begin
        res_found   = 1'b1;
        res_idx     = 8'(i);
        res_mask    = {NUM_IRQ{1'b0}};
        res_mask[i] = 1'b1;
      end
    end
    res_vector = res_found ? (VECTOR_BASE + (res_idx << 3)) : 8'h00;
  end

  // --------------------------------------------------------------------------
  // Registers: IE, IF, request history
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q     <= 8'h00;
      if_q     <= {{(NUM_IRQ-1){1'b0}}, 1'b1};
      irq_prev <= {NUM_IRQ{1'b0}};
    end else begin
      irq_prev <= irq_in;
      if_q     <= if_next;
      if (wr_ie)
        ie_q <= bus.bus_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // IME / EI delay. Priority: DI > dispatch entry > RETI > EI > boundary
  // promotion of a pending EI. RETI/EI/boundary are ignored mid-dispatch.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ime      <= 1'b0;
      ei_delay <= 1'b0;
    end else if (cmd_di) begin
      ime      <= 1'b0;
      ei_delay <= 1'b0;
    end else if (enter_d1) begin
      ime      <= 1'b0;
      ei_delay <= 1'b0;
    end else if (!dispatch_active) begin
      if (cmd_reti) begin
        ime <= 1'b1;
        if (instr_boundary)
          ei_delay <= 1'b0;
      end else if (cmd_ei) begin
        ei_delay <= 1'b1;
      end else if (instr_boundary && ei_delay) begin
        ime      <= 1'b1;
        ei_delay <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Dispatch FSM with registered strobes: each strobe is set on the edge
  // entering its state and dropped on the edge leaving it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= ST_IDLE;
      dispatch_active        <= 1'b0;
      push_pc_hi             <= 1'b0;
      push_pc_lo             <= 1'b0;
      write_interrupt_vector <= 1'b0;
      vector_q               <= 8'h00;
      clr_mask               <= {NUM_IRQ{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (enter_d1) begin
            state           <= ST_D1;
            dispatch_active <= 1'b1;
          end
        end
        ST_D1: state <= ST_D2;
        ST_D2: begin
          state      <= ST_D3;
          push_pc_hi <= 1'b1;
        end
        ST_D3: begin
          state      <= ST_D4;
          push_pc_hi <= 1'b0;
          push_pc_lo <= 1'b1;
        end
        ST_D4: begin
          state                  <= ST_D5;
          push_pc_lo             <= 1'b0;
          write_interrupt_vector <= 1'b1;
          vector_q               <= res_vector;
          clr_mask               <= res_mask;
        end
        ST_D5: begin
          state                  <= ST_IDLE;
          dispatch_active        <= 1'b0;
          write_interrupt_vector <= 1'b0;
          vector_q               <= 8'h00;
          clr_mask               <= {NUM_IRQ{1'b0}};
        end
        default: begin
          state                  <= ST_IDLE;
          dispatch_active        <= 1'b0;
          push_pc_hi             <= 1'b0;
          push_pc_lo             <= 1'b0;
          write_interrupt_vector <= 1'b0;
          vector_q               <= 8'h00;
          clr_mask               <= {NUM_IRQ{1'b0}};
        end
      endcase
    end
  end

  assign interrupt_vector = vector_q;
  assign dbg_state        = state;

endmodule
